// File: rtl/t04_keypad_scan_fifo_if.sv
// Key-event stream between the keypad scanner and its consumer.
// The master drives the FIFO head; the slave returns ready.
interface t04_keypad_scan_fifo_if #(
    parameter int unsigned CodeW = 4
);
    logic             evt_valid;
    logic             evt_ready;
    logic [CodeW-1:0] evt_code;
    logic             evt_press;
    logic             evt_repeat;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_press,
        output evt_repeat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_press,
        input  evt_repeat,
        output evt_ready
    );
endinterface

// File: rtl/t04_keypad_scan_fifo.sv
// Matrix keypad scanner with per-key debounce, event FIFO and app-mode tracking.
// Optional typematic repeat is enabled by defining KEYPAD_REPEAT_EN.
module t04_keypad_scan_fifo #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SCAN_TICKS = 16,
    parameter int unsigned DEB_SCANS  = 3,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_APPS   = 4,
    parameter int unsigned MODE_KEY   = 15,
`ifdef KEYPAD_REPEAT_EN
    parameter int unsigned REPEAT_DELAY_SCANS = 32,
    parameter int unsigned REPEAT_RATE_SCANS  = 8,
`endif
    localparam int unsigned NumKeys = ROWS * COLS,
    localparam int unsigned CodeW   = (NumKeys > 1) ? $clog2(NumKeys) : 1,
    localparam int unsigned AppW    = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ROWS-1:0]       row,
    output logic [COLS-1:0]       column,
    t04_keypad_scan_fifo_if.master evt,
    output logic [NumKeys-1:0]    key_state,
    output logic [AppW-1:0]       app,
    output logic                  overflow,
    input  logic                  ovf_clr
);
    localparam int unsigned TickW     = $clog2(SCAN_TICKS);
    localparam int unsigned ColW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RowW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CntW      = $clog2(DEB_SCANS + 1);
    localparam int unsigned PtrW      = $clog2(DEPTH);
    localparam int unsigned EntW      = CodeW + 2;
    localparam int unsigned EvalStart = SCAN_TICKS - ROWS;

    logic [ROWS-1:0]    row_s1_q, row_s2_q;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [ColW-1:0]    col_q, col_d;
    logic [COLS-1:0]    column_q, column_d;
    logic [CntW-1:0]    cnt_q [NumKeys];
    logic [CntW-1:0]    cnt_cur, cnt_new;
    logic [NumKeys-1:0] key_state_q, key_state_d;
    logic [AppW-1:0]    app_q, app_d;
    logic               ovf_q, ovf_d;
    logic [EntW-1:0]    mem_q [DEPTH];
    logic [PtrW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic               valid_q, valid_d;
    logic [EntW-1:0]    head_q, head_d;

    logic               eval_en, sample, cur_state;
    logic [RowW-1:0]    r_idx;
    logic [CodeW-1:0]   key_idx;
    logic               flip, flip_press;
    logic               push, push_press, push_rep;
    logic               pop, full, accept, drop;
    logic [EntW-1:0]    entry;

    // Scan timing: one column slot lasts SCAN_TICKS cycles.
    always_comb begin
        tick_d = tick_q + 1'b1;
        col_d  = col_q;
        if (tick_q == TickW'(SCAN_TICKS - 1)) begin
            tick_d = '0;
            col_d  = (col_q == ColW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
        column_d = COLS'(1) << col_d;
    end

    // The last ROWS ticks of each slot evaluate one key each, leaving the
    // earlier ticks for the synchroniser to settle after the column switch.
    always_comb begin
        eval_en   = (tick_q >= TickW'(EvalStart));
        r_idx     = RowW'(tick_q - TickW'(EvalStart));
        key_idx   = CodeW'(32'(col_q) * ROWS + 32'(r_idx));
        sample    = row_s2_q[r_idx];
        cur_state = key_state_q[key_idx];
        cnt_cur   = cnt_q[key_idx];
    end

    always_comb begin
        cnt_new     = cnt_cur;
        key_state_d = key_state_q;
        flip        = 1'b0;
        flip_press  = 1'b0;
        if (eval_en) begin
            if (sample != cur_state) begin
                if (cnt_cur == CntW'(DEB_SCANS - 1)) begin
                    cnt_new              = '0;
                    key_state_d[key_idx] = sample;
                    flip                 = 1'b1;
                    flip_press           = sample;
                end else begin
                    cnt_new = cnt_cur + 1'b1;
                end
            end else begin
                cnt_new = '0;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic             rep_active_q, rep_active_d;
    logic             rep_first_q, rep_first_d;
    logic [CodeW-1:0] rep_key_q, rep_key_d;
    logic [31:0]      rep_cnt_q, rep_cnt_d;
    logic             rep_push;
    logic [31:0]      rep_target;

    always_comb begin
        rep_active_d = rep_active_q;
        rep_first_d  = rep_first_q;
        rep_key_d    = rep_key_q;
        rep_cnt_d    = rep_cnt_q;
        rep_push     = 1'b0;
        rep_target   = rep_first_q ? REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
        if (eval_en) begin
            if (flip && flip_press) begin
                rep_active_d = 1'b1;
                rep_first_d  = 1'b1;
                rep_key_d    = key_idx;
                rep_cnt_d    = '0;
            end else if (flip && key_idx == rep_key_q) begin
                rep_active_d = 1'b0;
            end else if (!flip && rep_active_q && key_idx == rep_key_q) begin
                if (rep_cnt_q + 32'd1 >= rep_target) begin
                    rep_push    = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 32'd1;
                end
            end
        end
        push       = flip | rep_push;
        push_press = flip ? flip_press : 1'b1;
        push_rep   = !flip && rep_push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_active_q <= 1'b0;
            rep_first_q  <= 1'b0;
            rep_key_q    <= '0;
            rep_cnt_q    <= '0;
        end else begin
            rep_active_q <= rep_active_d;
            rep_first_q  <= rep_first_d;
            rep_key_q    <= rep_key_d;
            rep_cnt_q    <= rep_cnt_d;
        end
    end
`else
    always_comb begin
        push       = flip;
        push_press = flip_press;
        push_rep   = 1'b0;
    end
`endif

    // Only debounced presses advance the mode; repeats and releases do not.
    always_comb begin
        app_d = app_q;
        if (MODE_KEY < NumKeys && flip && flip_press && key_idx == CodeW'(MODE_KEY)) begin
            app_d = (app_q == AppW'(NUM_APPS - 1)) ? '0 : app_q + 1'b1;
        end
    end

    always_comb begin
        pop    = valid_q && evt.evt_ready;
        full   = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
        accept = push && (!full || pop);
        drop   = push && full && !pop;
        entry  = {key_idx, push_press, push_rep};
        wptr_d = wptr_q + (PtrW + 1)'(accept);
        rptr_d = rptr_q + (PtrW + 1)'(pop);
        ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        valid_d = (wptr_d != rptr_d);
        head_d  = '0;
        // The head register is refilled from the entry being written when
        // that entry lands exactly at the new read position.
        if (valid_d) begin
            if (accept && wptr_q[PtrW-1:0] == rptr_d[PtrW-1:0]) begin
                head_d = entry;
            end else begin
                head_d = mem_q[rptr_d[PtrW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q    <= '0;
            row_s2_q    <= '0;
            tick_q      <= '0;
            col_q       <= '0;
            column_q    <= COLS'(1);
            key_state_q <= '0;
            app_q       <= '0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            valid_q     <= 1'b0;
            head_q      <= '0;
            for (int i = 0; i < NumKeys; i++) cnt_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            row_s1_q    <= row;
            row_s2_q    <= row_s1_q;
            tick_q      <= tick_d;
            col_q       <= col_d;
            column_q    <= column_d;
            key_state_q <= key_state_d;
            app_q       <= app_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            valid_q     <= valid_d;
            head_q      <= head_d;
            if (eval_en) cnt_q[key_idx] <= cnt_new;
            if (accept) mem_q[wptr_q[PtrW-1:0]] <= entry;
        end
    end

    assign column         = column_q;
    assign key_state      = key_state_q;
    assign app            = app_q;
    assign overflow       = ovf_q;
    assign evt.evt_valid  = valid_q;
    assign evt.evt_code   = head_q[EntW-1:2];
    assign evt.evt_press  = head_q[1];
    assign evt.evt_repeat = head_q[0];
endmodule
